// File: rtl/apb_mem_pkg.sv
// Shared types, constants and parameter-legality helpers for the APB memory slave.
package apb_mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int WAIT_CNT_W = 4;

    function automatic int byte_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Word-addressable space must be able to hold DEPTH words.
    function automatic bit params_legal(input int addr_w, input int data_w,
                                        input int depth, input int wait_states);
        bit ok_s;
        ok_s = (data_w == 8) || (data_w == 16) || (data_w == 32);
        ok_s = ok_s && (wait_states >= 0) && (wait_states < (1 << WAIT_CNT_W));
        ok_s = ok_s && (depth >= 1) && (addr_w < 32);
        ok_s = ok_s && (depth <= (1 << (addr_w - byte_shift(data_w))));
        return ok_s;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage with a registered read port and per-byte-lane write enables.
module apb_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_W-1:0]     rdata,
    input  logic [DATA_W/8-1:0]   we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata
);

    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Read holding register, loaded only on an enabled read
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    // Byte-lane writes; storage is intentionally not reset (SRAM-macro compatible)
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we[i]) begin
                mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/apb_mem_slave_p.sv
// Parametrised APB3 memory slave: wait states, byte strobes, PSLVERR on out-of-range words.
module apb_mem_slave_p
    import apb_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_W-1:0]     PADDR,
    input  logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W/8-1:0]   PSTRB,
    output logic [DATA_W-1:0]     PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int LANES  = DATA_W / 8;
    localparam int SHIFT  = byte_shift(DATA_W);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0]           DEPTH_U   = 32'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] CNT_ZERO  = {WAIT_CNT_W{1'b0}};
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = {{(WAIT_CNT_W-1){1'b0}}, 1'b1};

    if (!params_legal(ADDR_W, DATA_W, DEPTH, WAIT_STATES)) begin : g_param_check
        $error("apb_mem_slave_p: illegal ADDR_W/DATA_W/DEPTH/WAIT_STATES combination");
    end

    state_e                  state_r, state_nxt_s;
    logic [WAIT_CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [MEM_AW-1:0]       idx_r;
    logic                    wr_r, oor_r;
    logic [DATA_W-1:0]       wdata_r;
    logic [LANES-1:0]        strb_r;
    logic                    pready_r, pslverr_r, rd_ok_r;
    logic                    pready_nxt_s, pslverr_nxt_s, rd_ok_nxt_s;
    logic                    eff_wr_s, eff_oor_s;
    logic [ADDR_W-1:0]       idx_s;
    logic                    oor_s, setup_s, go_s, complete_s;
    logic                    mem_re_s;
    logic [LANES-1:0]        mem_we_s;
    logic [DATA_W-1:0]       rdata_s;

    assign idx_s      = PADDR >> SHIFT;
    assign oor_s      = 32'(idx_s) >= DEPTH_U;
    assign setup_s    = (state_r == IDLE) && PSEL && !PENABLE;
    assign go_s       = (state_r == ACCESS) && PSEL && PENABLE;
    assign complete_s = go_s && (cnt_r == CNT_ZERO);

    // State register, wait counter and registered bus responses
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            rd_ok_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            pready_r  <= pready_nxt_s;
            pslverr_r <= pslverr_nxt_s;
            rd_ok_r   <= rd_ok_nxt_s;
        end
    end

    // Transfer attributes captured during the setup phase; ignored afterwards
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            idx_r   <= {MEM_AW{1'b0}};
            wr_r    <= 1'b0;
            oor_r   <= 1'b0;
            wdata_r <= {DATA_W{1'b0}};
            strb_r  <= {LANES{1'b0}};
        end else if (setup_s) begin
            idx_r   <= idx_s[MEM_AW-1:0];
            wr_r    <= PWRITE;
            oor_r   <= oor_s;
            wdata_r <= PWDATA;
            strb_r  <= PSTRB;
        end
    end

    // Next-state decode; a master abort (PSEL low) drops straight back to IDLE
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    state_nxt_s = ACCESS;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                if (!PSEL || complete_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACCESS;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Counter, memory strobes and next values of the registered responses
    always_comb begin
        cnt_nxt_s = cnt_r;
        mem_re_s  = 1'b0;
        mem_we_s  = {LANES{1'b0}};
        if (setup_s) begin
            cnt_nxt_s = WAIT_INIT;
            mem_re_s  = !PWRITE && !oor_s;
        end else if (go_s && (cnt_r != CNT_ZERO)) begin
            cnt_nxt_s = cnt_r - CNT_ONE;
        end else if (state_nxt_s == IDLE) begin
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (complete_s && wr_r && !oor_r) begin
            mem_we_s = strb_r;
        end else begin
            mem_we_s = {LANES{1'b0}};
        end
        eff_wr_s      = setup_s ? PWRITE : wr_r;
        eff_oor_s     = setup_s ? oor_s : oor_r;
        pready_nxt_s  = (state_nxt_s == ACCESS) && (cnt_nxt_s == CNT_ZERO);
        pslverr_nxt_s = pready_nxt_s && eff_oor_s;
        rd_ok_nxt_s   = pready_nxt_s && !eff_wr_s && !eff_oor_s;
    end

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_array (
        .clk   (PCLK),
        .re    (mem_re_s),
        .raddr (idx_s[MEM_AW-1:0]),
        .rdata (rdata_s),
        .we    (mem_we_s),
        .waddr (idx_r),
        .wdata (wdata_r)
    );

    assign PREADY  = pready_r;
    assign PSLVERR = pslverr_r;
    assign PRDATA  = rd_ok_r ? rdata_s : {DATA_W{1'b0}};

endmodule

// File: doc/apb_mem_slave_p.md
Name: apb_mem_slave_p

Overview:
- Parametrised APB3 memory slave; successor to the fixed 8-bit, 64-entry slave memories on the APB bridge bus.
- Adds configurable data, address and depth parameters.
- Adds programmable wait states, PSTRB byte-lane writes and PSLVERR on out-of-range access.
- Replaces combinational PREADY/memory updates with a clocked FSM; sits behind the bridge's PSELx decode like the existing slaves.

Parameters:
- ADDR_W, 8, PADDR width (byte address).
- DATA_W, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
- DEPTH, 64, number of DATA_W words; need not be a power of two.
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion (0..15).

Ports:
- PCLK  in  1  bus clock; all state on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  byte-lane write enables.
- PRDATA  out  DATA_W  read data, valid when PREADY=1.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid when PREADY=1.

Behaviour:
- Reset is one clock, asynchronous active-high on PRESET. While PRESET=1:
  - state=IDLE; PREADY=0, PSLVERR=0, PRDATA=0, wait counter=0.
  - Memory contents are not reset (X until written).
- Word index = PADDR >> log2(DATA_W/8). Low address bits are ignored, so there is no misalignment error.
- Range check: idx >= DEPTH is out of range.
- States: IDLE, ACCESS.
- IDLE:
  - PREADY=0.
  - On PSEL=1 & PENABLE=0 (setup): latch idx, PWRITE, PWDATA, PSTRB and range flag.
  - Load cnt=WAIT_STATES.
  - For an in-range read, register mem[idx] into the read-data holding register.
  - Go to ACCESS.
  - PSEL=1 & PENABLE=1 while in IDLE is a protocol violation: ignore it and stay in IDLE.
- ACCESS:
  - PREADY = (cnt==0), decoded from registers only, with no combinational path from bus inputs.
  - If PSEL & PENABLE & cnt!=0: cnt--.
  - If PSEL & PENABLE & cnt==0 (completion cycle):
    - In-range write: each lane i with PSTRB[i]=1 writes PWDATA byte i (latched value) at the edge.
    - Out-of-range: PSLVERR=1 and no memory write.
    - Go to IDLE.
  - If PSEL=0 (master abort): go to IDLE with no write; PREADY is never asserted for that transfer.
- Latency: PREADY rises in access cycle WAIT_STATES+1. With WAIT_STATES=0 it is high in the first access cycle (zero-wait APB).
- PRDATA:
  - Holding register value when PREADY=1, the transfer is a read and it is in range.
  - 0 otherwise, including writes and out-of-range reads.
- PSLVERR is only ever 1 while PREADY=1.
- Address, data and strobe changes during ACCESS are ignored; latched values are used.
- Back-to-back: the cycle after completion the FSM is in IDLE and accepts a new setup immediately. Sustained throughput is one transfer per WAIT_STATES+2 cycles.
- Read-after-write to the same word returns the new data, because the write commits at the completion edge, before the next setup's read.
- All-zero PSTRB write: completes normally with PSLVERR=0 and memory unchanged.
- PRESET asserted mid-ACCESS: immediate return to IDLE with all outputs 0. An in-flight write is dropped if the completion edge was not reached.

Decomposition:
- Package apb_mem_pkg:
  - state enum {IDLE, ACCESS}.
  - function clog2-based BYTE_SHIFT(DATA_W).
  - WAIT_CNT_W=4 constant.
  - Parameter legality checks (DATA_W in {8,16,32}; WAIT_STATES<16; DEPTH <= 2**(ADDR_W-BYTE_SHIFT)).
- Sub-module apb_mem_array:
  - DEPTH x DATA_W byte-enable RAM with registered read port and per-lane write enable.
  - Keeps the storage separable from the FSM for later SRAM macro substitution.

Test Plan:
- Reset then read: PRESET pulse, read idx 0 with WAIT_STATES=0 → PREADY high in first access cycle, PSLVERR=0; PRDATA 0 before and after PREADY.
- Write then read: write 0xDEADBEEF, PSTRB=4'hF at PADDR 0x10, then read 0x10 → PRDATA=0xDEADBEEF; a second back-to-back transfer completes with no idle gap.
- Byte strobes: write 0x11223344 with PSTRB=4'b0101 over existing 0xDEADBEEF → read returns 0xDE22BE44.
- Wait states: WAIT_STATES=3, read → PREADY low for 3 access cycles and high on the 4th; cnt stalls while PENABLE=0.
- Out of range: DEPTH=48, write PADDR 0xC0 (idx 48) then read it → both complete with PSLVERR=1, read PRDATA=0; idx 47 is unchanged.
- Abort and reset: WAIT_STATES=2, drop PSEL in the 2nd access cycle of a write → no memory change; assert PRESET mid-ACCESS → PREADY/PSLVERR/PRDATA go 0 asynchronously; next transfer completes normally.
